conv_tap_sequencer: RTL and testbench

//  Upstream feeder for the accumulator control FSM and its datapath. Accepts one

---
 rtl/conv_tap_sequencer_if.sv | 57 +++++
 rtl/conv_tap_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_conv_tap_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_tap_sequencer_if.sv
// ---------------------------------------------------------------------------
// conv_tap_sequencer_if
//   Bundles every non-clock signal of the convolution tap sequencer: the
//   window/kernel handshake, the accumulator-control request/response pair,
//   the per-tap datapath operands and the result handshake.
//
//   modport slave  : the sequencer itself.
//   modport master : its environment (window producer, accumulator control
//                    plus datapath, and result consumer).
//
//   Signals
//     win_valid/win_ready   window + kernel handshake
//     win_pixels            tap i at [i*PIX_W +: PIX_W], unsigned
//     kernel                coef i at [i*COEF_W +: COEF_W], signed
//     acc_clear/acc_start   single-cycle requests to the accumulator control
//     acc_ready             accumulator control idle
//     tap_pixel/tap_coef    operands of the tap currently being issued
//     acc_value             signed accumulator contents
//     out_valid/out_ready   result handshake
//     out_data              clamped result pixel
//     busy                  sequencer not idle
// ---------------------------------------------------------------------------
interface conv_tap_sequencer_if #(
   parameter int TAPS   = 9,
   parameter int PIX_W  = 8,
   parameter int COEF_W = 8,
   parameter int ACC_W  = 20
);

   logic                     win_valid;
   logic                     win_ready;
   logic [TAPS*PIX_W-1:0]    win_pixels;
   logic [TAPS*COEF_W-1:0]   kernel;
   logic                     acc_clear;
   logic                     acc_start;
   logic                     acc_ready;
   logic [PIX_W-1:0]         tap_pixel;
   logic [COEF_W-1:0]        tap_coef;
   logic [ACC_W-1:0]         acc_value;
   logic                     out_valid;
   logic                     out_ready;
   logic [PIX_W-1:0]         out_data;
   logic                     busy;

   modport slave (
      input  win_valid, win_pixels, kernel, acc_ready, acc_value, out_ready,
      output win_ready, acc_clear, acc_start, tap_pixel, tap_coef,
             out_valid, out_data, busy
   );

   modport master (
      output win_valid, win_pixels, kernel, acc_ready, acc_value, out_ready,
      input  win_ready, acc_clear, acc_start, tap_pixel, tap_coef,
             out_valid, out_data, busy
   );

endinterface

// File: rtl/conv_tap_sequencer.sv
// ---------------------------------------------------------------------------
// conv_tap_sequencer
//   Upstream feeder for the accumulator control FSM and its datapath. It
//   captures one TAPS-wide window plus kernel, requests one accumulator
//   clear, then issues one start per tap while presenting that tap's
//   pixel/coefficient pair. After the last tap has been summed it shifts and
//   clamps the accumulator into an output pixel held behind valid/ready.
//
//   Ports
//     clk    rising-edge clock
//     n_rst  asynchronous active-low reset
//     bus    conv_tap_sequencer_if.slave (see the interface for signals)
//
//   Parameters must match those of the connected interface instance.
// ---------------------------------------------------------------------------
module conv_tap_sequencer #(
   parameter int TAPS   = 9,
   parameter int PIX_W  = 8,
   parameter int COEF_W = 8,
   parameter int ACC_W  = 20,
   parameter int SHIFT  = 4
) (
   input  logic                 clk,
   input  logic                 n_rst,
   conv_tap_sequencer_if.slave  bus
);

   localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

   localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(TAPS - 1);
   localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'((2 ** PIX_W) - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_CLR_WAIT,
      S_ISSUE,
      S_TAP_WAIT,
      S_OUT
   } state_t;

   state_t                  state_q,     state_d;
   logic [IDX_W-1:0]        tap_idx_q,   tap_idx_d;
   logic [TAPS*PIX_W-1:0]   pix_q,       pix_d;
   logic [TAPS*COEF_W-1:0]  coef_q,      coef_d;
   logic [PIX_W-1:0]        tap_pixel_q, tap_pixel_d;
   logic [COEF_W-1:0]       tap_coef_q,  tap_coef_d;
   logic [PIX_W-1:0]        out_data_q,  out_data_d;

   logic                    acc_clear;
   logic                    acc_start;
   logic [IDX_W-1:0]        next_idx;
   logic signed [ACC_W-1:0] shifted;
   logic [PIX_W-1:0]        clamped;

   assign next_idx = tap_idx_q + IDX_W'(1);

   // Final sum scaled down and saturated into the unsigned pixel range.
   assign shifted = $signed(bus.acc_value) >>> SHIFT;

   always_comb begin
      clamped = shifted[PIX_W-1:0];
      if (shifted[ACC_W-1]) begin
         clamped = '0;
      end else if (shifted > PIX_MAX) begin
         clamped = '1;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state and request logic
   // -----------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d     = state_q;
      tap_idx_d   = tap_idx_q;
      pix_d       = pix_q;
      coef_d      = coef_q;
      tap_pixel_d = tap_pixel_q;
      tap_coef_d  = tap_coef_q;
      out_data_d  = out_data_q;
      acc_clear   = 1'b0;
      acc_start   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.win_valid) begin
               pix_d       = bus.win_pixels;
               coef_d      = bus.kernel;
               // Tap 0 operands are loaded straight from the inputs so they
               // are already stable in the first ISSUE cycle.
               tap_pixel_d = bus.win_pixels[PIX_W-1:0];
               tap_coef_d  = bus.kernel[COEF_W-1:0];
               tap_idx_d   = '0;
               state_d     = S_CLEAR;
            end
         end

         S_CLEAR: begin
            acc_clear = bus.acc_ready;
            if (bus.acc_ready) begin
               state_d = S_CLR_WAIT;
            end
         end

         // The control drops acc_ready while it resets the accumulator;
         // waiting for it to return covers that whole window.
         S_CLR_WAIT: begin
            if (bus.acc_ready) begin
               state_d = S_ISSUE;
            end
         end

         S_ISSUE: begin
            acc_start = bus.acc_ready;
            if (bus.acc_ready) begin
               state_d = S_TAP_WAIT;
            end
         end

         // acc_ready returning means SUM0 has already written this tap, so on
         // the last tap acc_value is the complete sum.
         S_TAP_WAIT: begin
            if (bus.acc_ready) begin
               if (tap_idx_q == LAST_IDX) begin
                  out_data_d = clamped;
                  state_d    = S_OUT;
               end else begin
                  tap_idx_d   = next_idx;
                  tap_pixel_d = pix_q[next_idx*PIX_W +: PIX_W];
                  tap_coef_d  = coef_q[next_idx*COEF_W +: COEF_W];
                  state_d     = S_ISSUE;
               end
            end
         end

         S_OUT: begin
            if (bus.out_ready) begin
               tap_idx_d = '0;
               state_d   = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // State and data registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_IDLE;
         tap_idx_q   <= '0;
         // NOTE: the window/kernel store is reset as well; a mid-window
         // reset must leave no stale operands on tap_pixel/tap_coef.
         pix_q       <= '0;
         coef_q      <= '0;
         tap_pixel_q <= '0;
         tap_coef_q  <= '0;
         out_data_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // values that were present before this edge.
         state_q     <= state_d;
         tap_idx_q   <= tap_idx_d;
         pix_q       <= pix_d;
         coef_q      <= coef_d;
         tap_pixel_q <= tap_pixel_d;
         tap_coef_q  <= tap_coef_d;
         out_data_q  <= out_data_d;
      end
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign bus.win_ready = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.out_valid = (state_q == S_OUT);
   assign bus.acc_clear = acc_clear;
   assign bus.acc_start = acc_start;
   assign bus.tap_pixel = tap_pixel_q;
   assign bus.tap_coef  = tap_coef_q;
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_tap_sequencer
//   Drives the tap sequencer against a behavioural accumulator control plus
//   datapath (reg4 += pixel*coef, clear zeroes reg4). Expected results come
//   from the arithmetic of the window (sum, arithmetic shift, clamp) and the
//   expected latency from 4 + 6*TAPS plus every cycle the bench withheld
//   acc_ready while the control was otherwise idle.
// ---------------------------------------------------------------------------
module tb_conv_tap_sequencer;

   localparam int TAPS     = 9;
   localparam int PIX_W    = 8;
   localparam int COEF_W   = 8;
   localparam int ACC_W    = 20;
   localparam int SHIFT    = 4;
   localparam int BASE_LAT = 4 + 6 * TAPS;

   logic clk = 1'b0;
   logic n_rst;
   logic stall;

   always #5 clk = ~clk;

   conv_tap_sequencer_if #(
      .TAPS(TAPS), .PIX_W(PIX_W), .COEF_W(COEF_W), .ACC_W(ACC_W)
   ) bus ();

   conv_tap_sequencer #(
      .TAPS(TAPS), .PIX_W(PIX_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .SHIFT(SHIFT)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   int pix_a  [TAPS];
   int coef_a [TAPS];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // -----------------------------------------------------------------------
   // Accumulator control + datapath model. A clear keeps the control busy
   // for two cycles (CLR, RST); a start walks LOAD_P, LOAD_K, MUL0, SUM0.
   // -----------------------------------------------------------------------
   typedef enum int {C_IDLE, C_CLR, C_RST, C_LOAD_P, C_LOAD_K, C_MUL, C_SUM} ctrl_t;

   ctrl_t                    ctrl_st;
   logic                     ctrl_ready;
   logic [PIX_W-1:0]         dp_pix;
   logic signed [COEF_W-1:0] dp_coef;
   int                       dp_prod;
   int                       dp_acc;

   assign ctrl_ready    = (ctrl_st == C_IDLE);
   assign bus.acc_ready = ctrl_ready && !stall;
   assign bus.acc_value = ACC_W'(dp_acc);

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ctrl_st <= C_IDLE;
         dp_pix  <= '0;
         dp_coef <= '0;
         dp_prod <= 0;
         dp_acc  <= 0;
      end else begin
         case (ctrl_st)
            C_IDLE: begin
               if (bus.acc_clear)      ctrl_st <= C_CLR;
               else if (bus.acc_start) ctrl_st <= C_LOAD_P;
            end
            C_CLR:    begin dp_acc <= 0;                ctrl_st <= C_RST;    end
            C_RST:    begin                             ctrl_st <= C_IDLE;   end
            C_LOAD_P: begin dp_pix  <= bus.tap_pixel;   ctrl_st <= C_LOAD_K; end
            C_LOAD_K: begin dp_coef <= bus.tap_coef;    ctrl_st <= C_MUL;    end
            C_MUL:    begin dp_prod <= int'(dp_pix) * int'(dp_coef); ctrl_st <= C_SUM; end
            C_SUM:    begin dp_acc  <= dp_acc + dp_prod; ctrl_st <= C_IDLE;  end
            default:  ctrl_st <= C_IDLE;
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Pulse monitor: sampled 2 time units after each falling edge, once the
   // bench's own drives for that cycle have settled.
   // -----------------------------------------------------------------------
   int mon_starts = 0;
   int mon_clears = 0;

   always @(negedge clk) begin
      #2;
      if (bus.win_valid && bus.win_ready) begin
         mon_starts = 0;
         mon_clears = 0;
      end
      if (bus.acc_clear || bus.acc_start) begin
         check("pulse_needs_ready", bus.acc_ready, 1);
         check("pulse_exclusive", bus.acc_clear & bus.acc_start, 0);
      end
      if (bus.acc_clear) mon_clears++;
      if (bus.acc_start) begin
         if (mon_starts < TAPS) begin
            check($sformatf("tap%0d.pixel", mon_starts), bus.tap_pixel,
                  pix_a[mon_starts] & ((1 << PIX_W) - 1));
            check($sformatf("tap%0d.coef", mon_starts), bus.tap_coef,
                  coef_a[mon_starts] & ((1 << COEF_W) - 1));
         end
         mon_starts++;
      end
   end

   // -----------------------------------------------------------------------
   // Reference model and stimulus helpers
   // -----------------------------------------------------------------------
   function automatic int expected_out();
      int sum = 0;
      int s;
      for (int i = 0; i < TAPS; i++) sum += pix_a[i] * coef_a[i];
      s = sum >>> SHIFT;
      if (s < 0) return 0;
      if (s > (1 << PIX_W) - 1) return (1 << PIX_W) - 1;
      return s;
   endfunction

   task automatic fill(input int p, input int c);
      for (int i = 0; i < TAPS; i++) begin
         pix_a[i]  = p;
         coef_a[i] = c;
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < TAPS; i++) begin
         pix_a[i]  = int'($urandom_range(0, (1 << PIX_W) - 1));
         coef_a[i] = int'($urandom_range(0, (1 << COEF_W) - 1)) - (1 << (COEF_W - 1));
      end
   endtask

   task automatic drive_window();
      for (int i = 0; i < TAPS; i++) begin
         bus.win_pixels[i*PIX_W +: PIX_W]   = PIX_W'(pix_a[i]);
         bus.kernel[i*COEF_W +: COEF_W]     = COEF_W'(coef_a[i]);
      end
   endtask

   task automatic scramble_inputs();
      for (int i = 0; i < TAPS; i++) begin
         bus.win_pixels[i*PIX_W +: PIX_W] = PIX_W'($urandom);
         bus.kernel[i*COEF_W +: COEF_W]   = COEF_W'($urandom);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".win_ready"}, bus.win_ready, 1);
      check({tag, ".acc_clear"}, bus.acc_clear, 0);
      check({tag, ".acc_start"}, bus.acc_start, 0);
      check({tag, ".out_valid"}, bus.out_valid, 0);
      check({tag, ".busy"},      bus.busy,      0);
      check({tag, ".tap_pixel"}, bus.tap_pixel, 0);
      check({tag, ".tap_coef"},  bus.tap_coef,  0);
      check({tag, ".out_data"},  bus.out_data,  0);
   endtask

   // stall_mode: 0 none, 1 random acc_ready drops, 2 five-cycle drop on the
   // first ISSUE. junk: toggle win_valid with garbage while busy.
   task automatic run_window(input string tag, input int hold, input int stall_mode, input bit junk);
      int lat = 0;
      int extra = 0;
      int stall_left = 0;
      bit stall_used = 0;
      int exp_out;
      exp_out = expected_out();

      bus.out_ready = 1'b0;
      check({tag, ".win_ready_idle"}, bus.win_ready, 1);
      drive_window();
      bus.win_valid = 1'b1;
      @(negedge clk);
      bus.win_valid = 1'b0;
      scramble_inputs();
      check({tag, ".win_ready_busy"}, bus.win_ready, 0);
      check({tag, ".busy"}, bus.busy, 1);

      while (bus.out_valid !== 1'b1 && lat < BASE_LAT + 400) begin
         if (stall_mode == 2 && !stall_used && bus.acc_start === 1'b1) begin
            stall_left = 5;
            stall_used = 1'b1;
         end
         if (stall_mode == 1) begin
            stall = ($urandom_range(0, 7) == 0);
         end else if (stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
         end else begin
            stall = 1'b0;
         end
         if (stall && ctrl_ready) extra++;
         if (junk) begin
            bus.win_valid = 1'($urandom_range(0, 1));
            scramble_inputs();
         end
         @(negedge clk);
         lat++;
      end
      stall = 1'b0;
      bus.win_valid = 1'b0;

      check({tag, ".latency"}, lat, BASE_LAT + extra);
      check({tag, ".out_data"}, bus.out_data, exp_out);
      check({tag, ".starts"}, mon_starts, TAPS);
      check({tag, ".clears"}, mon_clears, 1);

      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         check({tag, ".hold_valid"}, bus.out_valid, 1);
         check({tag, ".hold_data"}, bus.out_data, exp_out);
         check({tag, ".hold_win_ready"}, bus.win_ready, 0);
      end

      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, ".done_valid"}, bus.out_valid, 0);
      check({tag, ".done_win_ready"}, bus.win_ready, 1);
      check({tag, ".done_busy"}, bus.busy, 0);
   endtask

   // -----------------------------------------------------------------------
   // Main sequence
   // -----------------------------------------------------------------------
   initial begin
      int guard;
      int seen_valid;
      int seen_busy;

      n_rst          = 1'b0;
      stall          = 1'b0;
      bus.win_valid  = 1'b0;
      bus.win_pixels = '0;
      bus.kernel     = '0;
      bus.out_ready  = 1'b0;
      fill(0, 0);

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      n_rst = 1'b1;
      @(negedge clk);

      fill(16, 1);    run_window("unity", 0, 0, 0);
      fill(100, -1);  run_window("negative", 0, 0, 0);
      fill(255, 16);  run_window("saturate", 0, 0, 0);
      fill_random();  run_window("backpressure", 10, 0, 0);
      fill(16, 1);    run_window("stall", 0, 2, 0);

      // Reset while tap 5 is in flight.
      fill_random();
      drive_window();
      bus.win_valid = 1'b1;
      @(negedge clk);
      bus.win_valid = 1'b0;
      guard = 0;
      while (mon_starts < 5 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      check("mid_reset.reached_tap5", 32'(mon_starts >= 5), 1);
      @(negedge clk);
      n_rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("mid_reset");
      @(negedge clk);
      n_rst = 1'b1;
      seen_valid = 0;
      seen_busy  = 0;
      repeat (BASE_LAT + 10) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) seen_valid++;
         if (bus.busy !== 1'b0) seen_busy++;
      end
      check("mid_reset.no_partial_result", seen_valid, 0);
      check("mid_reset.stays_idle", seen_busy, 0);

      fill(16, 1);    run_window("post_reset", 0, 0, 0);

      for (int n = 0; n < 20; n++) begin
         fill_random();
         run_window($sformatf("rand%0d", n), int'($urandom_range(0, 3)), 1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
